// File: rtl/master_queue_port.sv
// Queued bus master: buffers read/write commands in a FIFO and issues them one at a time on the crossbar master bus.
// Optional ack watchdog enabled by defining MQP_TIMEOUT_EN.
module master_queue_port #(
  parameter int unsigned pDepth   = 4,
  parameter int unsigned pTimeout = 16
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iCmd_valid,
  output logic                       oCmd_ready,
  input  logic [31:0]                iCmd_addr,
  input  logic [31:0]                iCmd_wdata,
  input  logic                       iCmd_oper,
  output logic                       oRsp_valid,
  output logic [31:0]                oRsp_rdata,
  output logic                       oRsp_oper,
  output logic                       oRsp_err,
  output logic [$clog2(pDepth):0]    oLevel,
  output logic                       master_req,
  output logic [31:0]                master_addr,
  output logic                       master_cmd,
  output logic [31:0]                master_wdata,
  input  logic                       master_ack,
  input  logic [31:0]                master_rdata
);

  localparam int unsigned PTR_W = $clog2(pDepth);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        oper;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  cmd_t             r_mem [pDepth];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_count;
  state_t           r_state;

  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_oper;
  logic        r_rsp_err;
  logic        r_req;
  logic [31:0] r_addr;
  logic        r_cmd;
  logic [31:0] r_wdata;

  logic w_push;
  logic w_pop;
  logic w_timeout;
  cmd_t w_in;
  cmd_t w_head;

  // Ready depends only on the registered count, so a full FIFO refuses even when popping.
  assign oCmd_ready = (r_count != LVL_W'(pDepth));
  assign w_push     = iCmd_valid && oCmd_ready;
  assign w_pop      = (r_state != S_REQ) && (r_count != '0);
  assign w_in       = '{addr: iCmd_addr, wdata: iCmd_wdata, oper: iCmd_oper};
  assign w_head     = r_mem[r_rd_ptr];

`ifdef MQP_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(pTimeout + 1);
  logic [TO_W-1:0] r_tcnt;

  assign w_timeout = (r_tcnt == TO_W'(pTimeout - 1));

  // Counts REQ cycles without ack; cleared whenever a command enters REQ.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_tcnt <= '0;
    end else if (w_pop) begin
      r_tcnt <= '0;
    end else if (r_state == S_REQ && !master_ack) begin
      r_tcnt <= r_tcnt + TO_W'(1);
    end
  end
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(pTimeout);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_oper  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_cmd       <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + LVL_W'(w_push) - LVL_W'(w_pop);

      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_pop) begin
            r_req   <= 1'b1;
            r_addr  <= w_head.addr;
            r_wdata <= w_head.wdata;
            r_cmd   <= w_head.oper;
            r_state <= S_REQ;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          // Ack takes priority over a watchdog expiry in the same cycle.
          if (master_ack) begin
            r_req       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_oper  <= r_cmd;
            r_rsp_rdata <= r_cmd ? 32'h0 : master_rdata;
            r_rsp_err   <= 1'b0;
            r_state     <= S_GAP;
          end else if (w_timeout) begin
            r_req       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_oper  <= r_cmd;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b1;
            r_state     <= S_GAP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oLevel       = r_count;
  assign oRsp_valid   = r_rsp_valid;
  assign oRsp_rdata   = r_rsp_rdata;
  assign oRsp_oper    = r_rsp_oper;
  assign oRsp_err     = r_rsp_err;
  assign master_req   = r_req;
  assign master_addr  = r_addr;
  assign master_cmd   = r_cmd;
  assign master_wdata = r_wdata;

endmodule

// File: tb/tb_master_queue_port.sv
// Directed bench for master_queue_port: write, read, full FIFO, back-to-back, watchdog and mid-op reset.
module tb_master_queue_port;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iCmd_valid;
  logic        oCmd_ready;
  logic [31:0] iCmd_addr;
  logic [31:0] iCmd_wdata;
  logic        iCmd_oper;
  logic        oRsp_valid;
  logic [31:0] oRsp_rdata;
  logic        oRsp_oper;
  logic        oRsp_err;
  logic [2:0]  oLevel;
  logic        master_req;
  logic [31:0] master_addr;
  logic        master_cmd;
  logic [31:0] master_wdata;
  logic        master_ack;
  logic [31:0] master_rdata;

  int checks   = 0;
  int failures = 0;

  master_queue_port #(.pDepth(4), .pTimeout(16)) dut (
    .iClk(iClk), .iRst(iRst),
    .iCmd_valid(iCmd_valid), .oCmd_ready(oCmd_ready),
    .iCmd_addr(iCmd_addr), .iCmd_wdata(iCmd_wdata), .iCmd_oper(iCmd_oper),
    .oRsp_valid(oRsp_valid), .oRsp_rdata(oRsp_rdata), .oRsp_oper(oRsp_oper),
    .oRsp_err(oRsp_err), .oLevel(oLevel),
    .master_req(master_req), .master_addr(master_addr), .master_cmd(master_cmd),
    .master_wdata(master_wdata), .master_ack(master_ack), .master_rdata(master_rdata)
  );

  always #5 iClk = ~iClk;

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] d, input logic op);
    iCmd_valid = 1'b1;
    iCmd_addr  = a;
    iCmd_wdata = d;
    iCmd_oper  = op;
  endtask

  initial begin
    logic [31:0] addrs [5];
    logic [31:0] iss   [3];
    logic [4:0]  pat;
    int          nrsp;
    int          niss;
    int          nhi;

    iRst = 1'b1; iCmd_valid = 1'b0; iCmd_addr = '0; iCmd_wdata = '0; iCmd_oper = 1'b0;
    master_ack = 1'b0; master_rdata = '0;
    tick(); tick();

    // Reset state
    chk("rst_ready", oCmd_ready, 1);
    chk("rst_rsp_valid", oRsp_valid, 0);
    chk("rst_rsp_err", oRsp_err, 0);
    chk("rst_rsp_oper", oRsp_oper, 0);
    chk("rst_rsp_rdata", oRsp_rdata, 0);
    chk("rst_req", master_req, 0);
    chk("rst_cmd", master_cmd, 0);
    chk("rst_addr", master_addr, 0);
    chk("rst_wdata", master_wdata, 0);
    chk("rst_level", oLevel, 0);
    iRst = 1'b0;
    tick();

    // Write: push at cycle 0, req from cycle 2, ack in cycle 5, response in cycle 6
    offer(32'h0000_1000, 32'hA5A5_A5A5, 1'b1);
    tick();                                   // cycle 1
    iCmd_valid = 1'b0;
    chk("wr_req_c1", master_req, 0);
    tick();                                   // cycle 2
    chk("wr_req_c2", master_req, 1);
    chk("wr_addr_c2", master_addr, 32'h0000_1000);
    chk("wr_cmd_c2", master_cmd, 1);
    chk("wr_wdata_c2", master_wdata, 32'hA5A5_A5A5);
    tick(); tick();                           // cycle 4
    chk("wr_req_c4", master_req, 1);
    chk("wr_addr_c4", master_addr, 32'h0000_1000);
    tick();                                   // cycle 5
    master_ack = 1'b1;
    tick();                                   // cycle 6
    master_ack = 1'b0;
    chk("wr_rsp_valid", oRsp_valid, 1);
    chk("wr_rsp_oper", oRsp_oper, 1);
    chk("wr_rsp_rdata", oRsp_rdata, 0);
    chk("wr_rsp_err", oRsp_err, 0);
    chk("wr_req_drop", master_req, 0);
    tick();
    chk("wr_rsp_pulse", oRsp_valid, 0);

    // Read
    offer(32'h0000_2004, 32'h0, 1'b0);
    tick();
    iCmd_valid = 1'b0;
    tick();
    chk("rd_req", master_req, 1);
    chk("rd_addr", master_addr, 32'h0000_2004);
    chk("rd_cmd", master_cmd, 0);
    master_ack = 1'b1; master_rdata = 32'hDEAD_BEEF;
    tick();
    master_ack = 1'b0; master_rdata = '0;
    chk("rd_rsp_valid", oRsp_valid, 1);
    chk("rd_rsp_rdata", oRsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_oper", oRsp_oper, 0);
    chk("rd_rsp_err", oRsp_err, 0);
    tick();
    chk("rd_rsp_pulse", oRsp_valid, 0);
    chk("rd_level", oLevel, 0);

    // Full FIFO: five pushes, the first goes to the bus, the next four fill the queue
    for (int k = 0; k < 5; k++) begin
      addrs[k] = 32'h0000_3000 + 32'(k * 4);
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("full_ready_%0d", k), oCmd_ready, 1);
      offer(addrs[k], 32'h1111_0000 + 32'(k), 1'b1);
      tick();
    end
    chk("full_level4", oLevel, 4);
    chk("full_ready0", oCmd_ready, 0);
    chk("full_req_head", master_addr, addrs[0]);
    offer(32'h0000_3FFC, 32'h0, 1'b1);         // sixth offer, must be refused
    tick();
    iCmd_valid = 1'b0;
    chk("full_refused_level", oLevel, 4);
    master_ack = 1'b1;
    tick();                                   // GAP
    master_ack = 1'b0;
    chk("full_ack_rsp", oRsp_valid, 1);
    chk("full_gap_level", oLevel, 4);
    tick();
    chk("full_level3", oLevel, 3);
    chk("full_ready1", oCmd_ready, 1);
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("drain_req_%0d", k), master_req, 1);
      chk($sformatf("drain_addr_%0d", k), master_addr, addrs[k]);
      master_ack = 1'b1;
      tick();
      master_ack = 1'b0;
      chk($sformatf("drain_rsp_%0d", k), oRsp_valid, 1);
      tick();
    end
    tick();
    chk("drain_no_sixth", master_req, 0);
    chk("drain_level0", oLevel, 0);

    // Back-to-back: ack in the first REQ cycle each
    offer(32'h0000_4000, 32'hB0, 1'b1);
    tick();
    offer(32'h0000_4004, 32'hB1, 1'b1);
    tick();
    offer(32'h0000_4008, 32'hB2, 1'b1);
    pat = '0; nrsp = 0; niss = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 5) pat = {pat[3:0], master_req};
      if (oRsp_valid) nrsp++;
      if (master_req && niss < 3) begin
        iss[niss] = master_addr;
        niss++;
      end
      master_ack = master_req;
      tick();
      iCmd_valid = 1'b0;
    end
    master_ack = 1'b0;
    chk("b2b_req_pattern", 32'(pat), 32'b10101);
    chk("b2b_rsp_count", 32'(nrsp), 3);
    chk("b2b_issue0", iss[0], 32'h0000_4000);
    chk("b2b_issue1", iss[1], 32'h0000_4004);
    chk("b2b_issue2", iss[2], 32'h0000_4008);

`ifdef MQP_TIMEOUT_EN
    // Watchdog: no ack, request drops after 16 REQ cycles with an error response
    offer(32'h0000_5000, 32'h0, 1'b0);
    tick();
    offer(32'h0000_5004, 32'h0, 1'b1);
    tick();
    iCmd_valid = 1'b0;
    nhi = 0;
    while (master_req && nhi < 40) begin
      nhi++;
      tick();
    end
    chk("wd_req_cycles", 32'(nhi), 16);
    chk("wd_req_drop", master_req, 0);
    chk("wd_rsp_valid", oRsp_valid, 1);
    chk("wd_rsp_err", oRsp_err, 1);
    chk("wd_rsp_rdata", oRsp_rdata, 0);
    tick();
    chk("wd_next_req", master_req, 1);
    chk("wd_next_addr", master_addr, 32'h0000_5004);
    master_ack = 1'b1;
    tick();
    master_ack = 1'b0;
    chk("wd_next_err", oRsp_err, 0);
    tick(); tick();
`else
    // No watchdog: request holds for 100 cycles with no response
    offer(32'h0000_5000, 32'h0, 1'b0);
    tick();
    iCmd_valid = 1'b0;
    tick();
    nhi = 0; nrsp = 0;
    for (int i = 0; i < 100; i++) begin
      if (master_req) nhi++;
      if (oRsp_valid) nrsp++;
      tick();
    end
    chk("nowd_req_held", 32'(nhi), 100);
    chk("nowd_no_rsp", 32'(nrsp), 0);
    chk("nowd_err_tied", oRsp_err, 0);
`endif

    // Reset mid-op: one command in REQ, two queued
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    offer(32'h0000_6000, 32'hC0, 1'b1);
    tick();
    offer(32'h0000_6004, 32'hC1, 1'b1);
    tick();
    offer(32'h0000_6008, 32'hC2, 1'b1);
    tick();
    iCmd_valid = 1'b0;
    chk("mid_req_before", master_req, 1);
    chk("mid_level_before", oLevel, 2);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    chk("mid_req_after", master_req, 0);
    chk("mid_level_after", oLevel, 0);
    chk("mid_no_rsp", oRsp_valid, 0);
    master_ack = 1'b1; master_rdata = 32'h1234_5678;
    tick();
    master_ack = 1'b0; master_rdata = '0;
    chk("late_ack_no_rsp", oRsp_valid, 0);
    chk("late_ack_req", master_req, 0);
    tick();
    chk("late_ack_no_rsp2", oRsp_valid, 0);
    chk("late_ack_level", oLevel, 0);
    chk("late_ack_ready", oCmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
